// File: rtl/spi_slave_exch_byte.sv
// spi_slave_exch_byte: SPI mode-0 slave byte exchanger.
// Oversamples sclk/cs_n/mosi on iclk and deserialises each received byte to orx_data.
// Serialises the byte in the transmit holding register on miso, and keeps doing so
// for back-to-back bytes while cs_n stays low.
// Ports:
//   iclk, irst          system clock, asynchronous active-high reset
//   imsb_lsb_sel        bit order (0 = MSB first), captured at each byte load
//   itx_data, itx_load  write port of the transmit holding register
//   otx_empty           holding register empty
//   ounderrun           pulse: a byte started with the holding register empty (0xFF sent)
//   orx_data, orx_valid received byte and its one-cycle update pulse
//   obusy               synchronised cs_n is low
//   sclk, cs_n, mosi    SPI pins from the master (asynchronous)
//   miso, miso_oe       SPI data out and its output enable
module spi_slave_exch_byte #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       imsb_lsb_sel,
    input  logic [7:0] itx_data,
    input  logic       itx_load,
    output logic       otx_empty,
    output logic       ounderrun,
    output logic [7:0] orx_data,
    output logic       orx_valid,
    output logic       obusy,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    localparam int unsigned BYTE  = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                     r_sclk_d, r_cs_d;
    logic [CNT_W-1:0]         r_bitcount, w_bitcount_nxt;
    logic [BYTE-1:0]          r_rx_sr, w_rx_sr_nxt;
    logic [BYTE-1:0]          r_tx_sr, w_tx_sr_nxt;
    logic [BYTE-1:0]          r_hold, w_hold_nxt;
    logic                     r_empty, w_empty_nxt;
    logic                     r_sel, w_sel_nxt;
    logic                     r_miso, w_miso_nxt;
    logic                     r_busy, w_busy_nxt;
    logic [BYTE-1:0]          r_rx_data, w_rx_data_nxt;
    logic                     r_rx_valid, w_rx_valid_nxt;
    logic                     r_underrun, w_underrun_nxt;
    logic                     w_load;
    logic [BYTE-1:0]          w_src, w_loaded, w_rx_shift;

    logic w_sclk_s, w_cs_s, w_mosi_s;
    logic w_rise, w_fall, w_cs_start, w_cs_end;

    function automatic logic [BYTE-1:0] f_rev(input logic [BYTE-1:0] d);
        logic [BYTE-1:0] r;
        r = '0;
        for (int i = 0; i < int'(BYTE); i++) r[i] = d[BYTE-1-i];
        return r;
    endfunction

    // Input synchronisers, preset to the idle pin levels, plus one delay stage for edges
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise     = w_sclk_s & ~r_sclk_d;
    assign w_fall     = ~w_sclk_s & r_sclk_d;
    assign w_cs_start = ~w_cs_s & r_cs_d;
    assign w_cs_end   = w_cs_s;

    // State register
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state, datapath and output values
    always_comb begin
        w_state_nxt    = r_state;
        w_bitcount_nxt = r_bitcount;
        w_rx_sr_nxt    = r_rx_sr;
        w_tx_sr_nxt    = r_tx_sr;
        w_hold_nxt     = r_hold;
        w_empty_nxt    = r_empty;
        w_sel_nxt      = r_sel;
        w_miso_nxt     = r_miso;
        w_busy_nxt     = r_busy;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_underrun_nxt = 1'b0;
        w_load         = 1'b0;
        w_src          = r_empty ? 8'hFF : r_hold;
        w_loaded       = '0;
        w_rx_shift     = r_sel ? {w_mosi_s, r_rx_sr[BYTE-1:1]} : {r_rx_sr[BYTE-2:0], w_mosi_s};

        case (r_state)
            IDLE: begin
                w_miso_nxt = 1'b1;
                w_busy_nxt = 1'b0;
                if (w_cs_start) begin
                    w_state_nxt    = ACTIVE;
                    w_load         = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_bitcount_nxt = '0;
                end
            end
            ACTIVE: begin
                if (w_cs_end) begin
                    // Abort discards any partial byte; holding register is left alone
                    w_state_nxt    = IDLE;
                    w_bitcount_nxt = '0;
                    w_miso_nxt     = 1'b1;
                    w_busy_nxt     = 1'b0;
                end else if (w_rise) begin
                    w_rx_sr_nxt    = w_rx_shift;
                    w_bitcount_nxt = CNT_W'(r_bitcount + CNT_W'(1));
                    if (r_bitcount == CNT_W'(BYTE - 1)) begin
                        w_rx_data_nxt  = w_rx_shift;
                        w_rx_valid_nxt = 1'b1;
                    end
                end else if (w_fall) begin
                    if (r_bitcount != '0) begin
                        w_miso_nxt  = r_tx_sr[0];
                        w_tx_sr_nxt = {1'b1, r_tx_sr[BYTE-1:1]};
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Byte load: tx shifter always emits bit 0 first, so MSB mode reverses the byte
        if (w_load) begin
            w_sel_nxt      = imsb_lsb_sel;
            w_loaded       = imsb_lsb_sel ? w_src : f_rev(w_src);
            w_miso_nxt     = w_loaded[0];
            w_tx_sr_nxt    = {1'b1, w_loaded[BYTE-1:1]};
            w_underrun_nxt = r_empty;
            w_empty_nxt    = 1'b1;
        end

        // A host write in the load cycle lands after the old content was consumed
        if (itx_load) begin
            w_hold_nxt  = itx_data;
            w_empty_nxt = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_bitcount <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_hold     <= '0;
            r_empty    <= 1'b1;
            r_sel      <= 1'b0;
            r_miso     <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_bitcount <= w_bitcount_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_tx_sr    <= w_tx_sr_nxt;
            r_hold     <= w_hold_nxt;
            r_empty    <= w_empty_nxt;
            r_sel      <= w_sel_nxt;
            r_miso     <= w_miso_nxt;
            r_busy     <= w_busy_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign otx_empty = r_empty;
    assign ounderrun = r_underrun;
    assign orx_data  = r_rx_data;
    assign orx_valid = r_rx_valid;
    assign obusy     = r_busy;
    assign miso      = r_miso;
    assign miso_oe   = r_busy;

endmodule

// File: tb/tb_spi_slave_exch_byte.sv
// Directed testbench for spi_slave_exch_byte: acts as an SPI mode-0 master.
module tb_spi_slave_exch_byte;

    localparam int H = 80;

    logic       iclk = 1'b0;
    logic       irst = 1'b1;
    logic       imsb_lsb_sel = 1'b0;
    logic [7:0] itx_data = 8'h00;
    logic       itx_load = 1'b0;
    logic       otx_empty, ounderrun, orx_valid, obusy, miso, miso_oe;
    logic [7:0] orx_data;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b1;

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;
    int urcnt    = 0;
    logic [7:0] last_rx = 8'h00;

    spi_slave_exch_byte #(.SYNC_STAGES(2)) dut (
        .iclk(iclk), .irst(irst), .imsb_lsb_sel(imsb_lsb_sel),
        .itx_data(itx_data), .itx_load(itx_load),
        .otx_empty(otx_empty), .ounderrun(ounderrun),
        .orx_data(orx_data), .orx_valid(orx_valid), .obusy(obusy),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe)
    );

    always #5 iclk = ~iclk;

    // Event monitors: received bytes and underrun pulses
    always @(negedge iclk) begin
        if (orx_valid === 1'b1) begin
            vcnt    <= vcnt + 1;
            last_rx <= orx_data;
        end
        if (ounderrun === 1'b1) urcnt <= urcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tx_load(input logic [7:0] d);
        @(negedge iclk);
        itx_data = d;
        itx_load = 1'b1;
        @(negedge iclk);
        itx_load = 1'b0;
    endtask

    // One mode-0 byte; optionally writes the holding register mid-byte
    task automatic spi_byte(input logic [7:0] tx, input bit lsb, input bit do_load,
                            input logic [7:0] ld, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mosi = lsb ? tx[i] : tx[7-i];
            #H;
            rx   = lsb ? {miso, rx[7:1]} : {rx[6:0], miso};
            sclk = 1'b1;
            if (do_load && i == 3) begin
                #(H/2);
                tx_load(ld);
                #(H/2);
            end else begin
                #H;
            end
            sclk = 1'b0;
        end
    endtask

    logic [7:0] rx;
    int v0, u0;

    initial begin
        // 1: reset state, then underrun exchange
        #23;
        chk("rst_miso", 32'(miso), 32'h1);
        chk("rst_oe", 32'(miso_oe), 32'h0);
        chk("rst_busy", 32'(obusy), 32'h0);
        chk("rst_empty", 32'(otx_empty), 32'h1);
        chk("rst_rxdata", 32'(orx_data), 32'h00);
        chk("rst_valid", 32'(orx_valid), 32'h0);
        chk("rst_underrun", 32'(ounderrun), 32'h0);
        @(negedge iclk);
        irst = 1'b0;
        #(2*H);
        v0 = vcnt; u0 = urcnt;
        cs_n = 1'b0;
        #H;
        chk("t1_busy", 32'(obusy), 32'h1);
        chk("t1_oe", 32'(miso_oe), 32'h1);
        spi_byte(8'hA5, 1'b0, 1'b0, 8'h00, rx);
        chk("t1_miso_byte", 32'(rx), 32'hFF);
        chk("t1_rx", 32'(last_rx), 32'hA5);
        chk("t1_valid_cnt", 32'(vcnt - v0), 32'd1);
        chk("t1_underrun_cnt", 32'(urcnt - u0), 32'd1);
        #H;
        cs_n = 1'b1;
        #(2*H);
        chk("t1_idle_busy", 32'(obusy), 32'h0);
        chk("t1_idle_miso", 32'(miso), 32'h1);

        // 2: MSB-first then LSB-first exchange
        tx_load(8'h3C);
        chk("t2_full", 32'(otx_empty), 32'h0);
        u0 = urcnt;
        cs_n = 1'b0;
        #H;
        chk("t2_empty_after_start", 32'(otx_empty), 32'h1);
        spi_byte(8'hC3, 1'b0, 1'b0, 8'h00, rx);
        chk("t2_msb_miso", 32'(rx), 32'h3C);
        chk("t2_msb_rx", 32'(last_rx), 32'hC3);
        chk("t2_no_underrun", 32'(urcnt - u0), 32'd0);
        #H;
        cs_n = 1'b1;
        #(2*H);
        imsb_lsb_sel = 1'b1;
        tx_load(8'h01);
        cs_n = 1'b0;
        #H;
        chk("t2_lsb_first_bit", 32'(miso), 32'h1);
        spi_byte(8'hC3, 1'b1, 1'b0, 8'h00, rx);
        chk("t2_lsb_miso", 32'(rx), 32'h01);
        chk("t2_lsb_rx", 32'(last_rx), 32'hC3);
        #H;
        cs_n = 1'b1;
        #(2*H);

        // 3: three back-to-back bytes with reloads between
        imsb_lsb_sel = 1'b0;
        tx_load(8'h11);
        v0 = vcnt; u0 = urcnt;
        cs_n = 1'b0;
        #H;
        spi_byte(8'h81, 1'b0, 1'b1, 8'h22, rx);
        chk("t3_miso0", 32'(rx), 32'h11);
        chk("t3_rx0", 32'(last_rx), 32'h81);
        spi_byte(8'h42, 1'b0, 1'b1, 8'h33, rx);
        chk("t3_miso1", 32'(rx), 32'h22);
        chk("t3_rx1", 32'(last_rx), 32'h42);
        spi_byte(8'h24, 1'b0, 1'b1, 8'h44, rx);
        chk("t3_miso2", 32'(rx), 32'h33);
        chk("t3_rx2", 32'(last_rx), 32'h24);
        #H;
        chk("t3_valid_cnt", 32'(vcnt - v0), 32'd3);
        chk("t3_no_underrun", 32'(urcnt - u0), 32'd0);
        cs_n = 1'b1;
        #(2*H);

        // 4: abort after five rises, then a clean byte
        v0 = vcnt;
        cs_n = 1'b0;
        #H;
        for (int i = 0; i < 5; i++) begin
            mosi = i[0];
            #H;
            sclk = 1'b1;
            #H;
            if (i < 4) sclk = 1'b0;
        end
        cs_n = 1'b1;
        #H;
        sclk = 1'b0;
        #(2*H);
        chk("t4_no_valid", 32'(vcnt - v0), 32'd0);
        chk("t4_miso", 32'(miso), 32'h1);
        chk("t4_busy", 32'(obusy), 32'h0);
        chk("t4_oe", 32'(miso_oe), 32'h0);
        v0 = vcnt;
        cs_n = 1'b0;
        #H;
        spi_byte(8'h5A, 1'b0, 1'b0, 8'h00, rx);
        chk("t4_rx", 32'(last_rx), 32'h5A);
        chk("t4_valid_cnt", 32'(vcnt - v0), 32'd1);
        #H;
        cs_n = 1'b1;
        #(2*H);

        // 5: holding write in the exact cs_start cycle while empty
        chk("t5_pre_empty", 32'(otx_empty), 32'h1);
        u0 = urcnt;
        @(negedge iclk);
        cs_n = 1'b0;
        @(negedge iclk);
        @(negedge iclk);
        itx_data = 8'h77;
        itx_load = 1'b1;
        @(negedge iclk);
        itx_load = 1'b0;
        #H;
        chk("t5_underrun", 32'(urcnt - u0), 32'd1);
        chk("t5_full", 32'(otx_empty), 32'h0);
        spi_byte(8'h0F, 1'b0, 1'b0, 8'h00, rx);
        chk("t5_miso0", 32'(rx), 32'hFF);
        chk("t5_full_between", 32'(otx_empty), 32'h0);
        spi_byte(8'hF0, 1'b0, 1'b0, 8'h00, rx);
        chk("t5_miso1", 32'(rx), 32'h77);
        chk("t5_rx1", 32'(last_rx), 32'hF0);
        #H;
        cs_n = 1'b1;
        #(2*H);

        // 6: asynchronous reset mid-byte, then a fresh exchange
        cs_n = 1'b0;
        #H;
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            #H;
            sclk = 1'b1;
            #H;
            sclk = 1'b0;
        end
        tx_load(8'h66);
        chk("t6_pre_full", 32'(otx_empty), 32'h0);
        #H;
        sclk = 1'b1;
        @(negedge iclk);
        #2;
        irst = 1'b1;
        #1;
        chk("t6_rst_miso", 32'(miso), 32'h1);
        chk("t6_rst_oe", 32'(miso_oe), 32'h0);
        chk("t6_rst_busy", 32'(obusy), 32'h0);
        chk("t6_rst_rxdata", 32'(orx_data), 32'h00);
        chk("t6_rst_empty", 32'(otx_empty), 32'h1);
        chk("t6_rst_valid", 32'(orx_valid), 32'h0);
        chk("t6_rst_underrun", 32'(ounderrun), 32'h0);
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b1;
        #(2*H);
        @(negedge iclk);
        irst = 1'b0;
        #(2*H);
        tx_load(8'h96);
        v0 = vcnt;
        cs_n = 1'b0;
        #H;
        spi_byte(8'h96, 1'b0, 1'b0, 8'h00, rx);
        chk("t6_miso", 32'(rx), 32'h96);
        chk("t6_rx", 32'(last_rx), 32'h96);
        chk("t6_valid_cnt", 32'(vcnt - v0), 32'd1);
        #H;
        cs_n = 1'b1;
        #(2*H);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
